// File: rtl/current_monitor_pkg.sv
// Shared types and helpers for the motor current monitor: FSM states,
// ADC code width and XADC word unpacking.
package current_monitor_pkg;

    localparam int ADC_CODE_W = 12;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        FAULT = 2'd2
    } state_t;

    // XADC left-justifies its 12-bit result; the low nibble carries no data.
    function automatic logic [ADC_CODE_W-1:0] xadc_code(input logic [15:0] word);
        return word[15:4];
    endfunction

endpackage

// File: rtl/moving_avg.sv
// Boxcar moving average over the last 2^AVG_LOG2 accepted codes, kept as a
// running sum over a circular history buffer.
module moving_avg
    import current_monitor_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [ADC_CODE_W-1:0] code,
    input  logic                  code_valid,
    output logic [ADC_CODE_W-1:0] avg,
    output logic                  avg_upd
);

    localparam int WINDOW = 1 << AVG_LOG2;
    localparam int SUM_W  = ADC_CODE_W + AVG_LOG2;

    logic [ADC_CODE_W-1:0] hist [WINDOW];
    logic [AVG_LOG2-1:0]   wr_ptr_reg;
    logic [AVG_LOG2-1:0]   rd_ptr;
    logic                  full_reg;
    logic [ADC_CODE_W-1:0] oldest_reg;
    logic [ADC_CODE_W-1:0] oldest;
    logic [SUM_W-1:0]      sum_reg;
    logic [SUM_W-1:0]      sum_next;
    logic [ADC_CODE_W-1:0] avg_reg;
    logic                  upd_reg;

    // The entry that the next accept will overwrite is prefetched one sample
    // ahead, so the history needs only a registered read port.
    assign rd_ptr = wr_ptr_reg + AVG_LOG2'(1);

    // Until the window has been filled once since reset, stale RAM contents
    // stand in for the cleared history and are read as zero.
    assign oldest   = full_reg ? oldest_reg : '0;
    assign sum_next = sum_reg + SUM_W'(code) - SUM_W'(oldest);

    always_ff @(posedge clk) begin
        if (code_valid) begin
            hist[wr_ptr_reg] <= code;
            oldest_reg       <= hist[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            full_reg   <= 1'b0;
            sum_reg    <= '0;
            avg_reg    <= '0;
            upd_reg    <= 1'b0;
        end else begin
            upd_reg <= code_valid;
            if (code_valid) begin
                wr_ptr_reg <= rd_ptr;
                sum_reg    <= sum_next;
                avg_reg    <= sum_next[SUM_W-1:AVG_LOG2];
                if (wr_ptr_reg == '1) begin
                    full_reg <= 1'b1;
                end
            end
        end
    end

    assign avg     = avg_reg;
    assign avg_upd = upd_reg;

endmodule

// File: rtl/current_monitor.sv
// Motor current monitor: moving-average current, debounced hysteretic
// overcurrent trip with latched fault, and motor drive enable.
module current_monitor
    import current_monitor_pkg::*;
#(
    parameter int AVG_LOG2    = 3,
    parameter int TRIP_LEVEL  = 950,
    parameter int CLEAR_LEVEL = 800,
    parameter int TRIP_COUNT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    input  logic        clear_fault,
    output logic [11:0] avg_current,
    output logic        avg_valid,
    output logic [11:0] peak_current,
    output logic        fault,
    output logic        motor_enable,
    output logic [1:0]  state_out
);

    localparam logic [ADC_CODE_W-1:0] TRIP_CODE  = ADC_CODE_W'(TRIP_LEVEL);
    localparam logic [ADC_CODE_W-1:0] CLEAR_CODE = ADC_CODE_W'(CLEAR_LEVEL);
    localparam logic [3:0]            TRIP_N     = 4'(TRIP_COUNT);
    localparam logic [AVG_LOG2-1:0]   FILL_LAST  = '1;

    logic [ADC_CODE_W-1:0] avg;
    logic                  avg_upd;
    logic                  avg_valid_int;

    state_t                state_reg, state_next;
    logic [AVG_LOG2-1:0]   fill_reg, fill_next;
    logic [3:0]            trip_reg, trip_next, base_trip;
    logic [ADC_CODE_W-1:0] peak_reg, peak_next, base_peak;
    logic [ADC_CODE_W-1:0] prev_avg_reg;
    logic                  fault_reg, motor_enable_reg;
    logic                  run_armed;
    logic                  clear_ok;

    moving_avg #(
        .AVG_LOG2(AVG_LOG2)
    ) u_avg (
        .clk       (clk),
        .srst      (reset),
        .code      (xadc_code(sample)),
        .code_valid(sample_valid),
        .avg       (avg),
        .avg_upd   (avg_upd)
    );

    assign avg_valid_int = avg_upd && (state_reg == ARMED || state_reg == FAULT);

    // prev_avg_reg lags avg by one cycle, so on an update cycle it still holds
    // the average that was current before the new sample landed.
    assign clear_ok = clear_fault && (prev_avg_reg < CLEAR_CODE);

    always_comb begin
        state_next = state_reg;
        fill_next  = fill_reg;
        trip_next  = trip_reg;
        peak_next  = peak_reg;
        base_trip  = trip_reg;
        base_peak  = peak_reg;
        run_armed  = 1'b0;

        case (state_reg)
            FILL: begin
                if (avg_upd) begin
                    if (fill_reg == FILL_LAST) begin
                        state_next = ARMED;
                        fill_next  = '0;
                    end else begin
                        fill_next = fill_reg + AVG_LOG2'(1);
                    end
                end
            end
            ARMED: begin
                run_armed = avg_valid_int;
            end
            FAULT: begin
                trip_next = '0;
                if (clear_ok) begin
                    // A simultaneous new average is judged as the first
                    // sample of a fresh ARMED period.
                    state_next = ARMED;
                    peak_next  = '0;
                    base_trip  = '0;
                    base_peak  = '0;
                    run_armed  = avg_valid_int;
                end
            end
            default: begin
                state_next = FILL;
                fill_next  = '0;
                trip_next  = '0;
                peak_next  = '0;
            end
        endcase

        if (run_armed) begin
            peak_next = (avg > base_peak) ? avg : base_peak;
            if (avg >= TRIP_CODE) begin
                if (base_trip + 4'd1 == TRIP_N) begin
                    state_next = FAULT;
                    trip_next  = '0;
                end else begin
                    trip_next = base_trip + 4'd1;
                end
            end else begin
                trip_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= FILL;
            fill_reg         <= '0;
            trip_reg         <= '0;
            peak_reg         <= '0;
            prev_avg_reg     <= '0;
            fault_reg        <= 1'b0;
            motor_enable_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            fill_reg         <= fill_next;
            trip_reg         <= trip_next;
            peak_reg         <= peak_next;
            prev_avg_reg     <= avg;
            fault_reg        <= (state_next == FAULT);
            motor_enable_reg <= (state_next == ARMED);
        end
    end

    assign avg_current  = avg;
    assign avg_valid    = avg_valid_int;
    assign peak_current = peak_reg;
    assign fault        = fault_reg;
    assign motor_enable = motor_enable_reg;
    assign state_out    = state_reg;

endmodule

// File: tb/tb_current_monitor.sv
// Bench for current_monitor: two instances (TRIP_COUNT 4 and 1) driven with
// shared directed and random stimulus, checked every cycle against a model.
module tb_current_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic        clear_fault = 1'b0;

    logic [11:0] avg_current_a, peak_current_a, avg_current_b, peak_current_b;
    logic        avg_valid_a, fault_a, motor_enable_a;
    logic        avg_valid_b, fault_b, motor_enable_b;
    logic [1:0]  state_out_a, state_out_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    current_monitor #(.AVG_LOG2(3), .TRIP_LEVEL(950), .CLEAR_LEVEL(800), .TRIP_COUNT(4)) dut_a (
        .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
        .clear_fault(clear_fault), .avg_current(avg_current_a), .avg_valid(avg_valid_a),
        .peak_current(peak_current_a), .fault(fault_a), .motor_enable(motor_enable_a),
        .state_out(state_out_a)
    );

    current_monitor #(.AVG_LOG2(3), .TRIP_LEVEL(950), .CLEAR_LEVEL(800), .TRIP_COUNT(1)) dut_b (
        .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
        .clear_fault(clear_fault), .avg_current(avg_current_b), .avg_valid(avg_valid_b),
        .peak_current(peak_current_b), .fault(fault_b), .motor_enable(motor_enable_b),
        .state_out(state_out_b)
    );

    // Reference model: averages recomputed from the raw sample history;
    // states are 0=FILL, 1=ARMED, 2=FAULT.
    int hist_q[$];
    int m_avg = 0;
    int m_avg_old = 0;
    bit m_upd = 0;
    int m_state[2] = '{0, 0};
    int m_fill[2] = '{0, 0};
    int m_trip[2] = '{0, 0};
    int m_peak[2] = '{0, 0};
    bit m_valid[2] = '{0, 0};
    int trip_n[2] = '{4, 1};

    task automatic check(string tag, int obs, int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(bit sv, int c, bit clr, bit rst);
        int clear_ref;
        int s;
        if (rst) begin
            hist_q = {};
            repeat (8) hist_q.push_back(0);
            m_avg = 0;
            m_avg_old = 0;
            m_upd = 0;
            for (int k = 0; k < 2; k++) begin
                m_state[k] = 0; m_fill[k] = 0; m_trip[k] = 0; m_peak[k] = 0; m_valid[k] = 0;
            end
            return;
        end
        clear_ref = m_upd ? m_avg_old : m_avg;
        for (int k = 0; k < 2; k++) begin
            int ns;
            bit run;
            ns = m_state[k];
            run = 0;
            case (m_state[k])
                0: if (m_upd) begin
                    m_fill[k]++;
                    if (m_fill[k] == 8) begin ns = 1; m_fill[k] = 0; end
                end
                1: run = m_valid[k];
                default: begin
                    m_trip[k] = 0;
                    if (clr && clear_ref < 800) begin
                        ns = 1; m_peak[k] = 0; run = m_valid[k];
                    end
                end
            endcase
            if (run) begin
                if (m_avg > m_peak[k]) m_peak[k] = m_avg;
                if (m_avg >= 950) begin
                    m_trip[k]++;
                    if (m_trip[k] >= trip_n[k]) begin ns = 2; m_trip[k] = 0; end
                end else begin
                    m_trip[k] = 0;
                end
            end
            m_state[k] = ns;
        end
        if (sv) begin
            m_avg_old = m_avg;
            hist_q.push_back(c);
            void'(hist_q.pop_front());
            s = 0;
            foreach (hist_q[i]) s += hist_q[i];
            m_avg = s / 8;
            m_upd = 1;
        end else begin
            m_upd = 0;
        end
        for (int k = 0; k < 2; k++) m_valid[k] = m_upd && (m_state[k] != 0);
    endtask

    task automatic compare_all();
        check("a.avg_current", avg_current_a, m_avg);
        check("a.avg_valid", avg_valid_a, m_valid[0]);
        check("a.peak_current", peak_current_a, m_peak[0]);
        check("a.fault", fault_a, m_state[0] == 2);
        check("a.motor_enable", motor_enable_a, m_state[0] == 1);
        check("a.state_out", state_out_a, m_state[0]);
        check("b.avg_current", avg_current_b, m_avg);
        check("b.avg_valid", avg_valid_b, m_valid[1]);
        check("b.peak_current", peak_current_b, m_peak[1]);
        check("b.fault", fault_b, m_state[1] == 2);
        check("b.motor_enable", motor_enable_b, m_state[1] == 1);
        check("b.state_out", state_out_b, m_state[1]);
    endtask

    task automatic cycle(bit sv, int c, bit clr, bit rst);
        logic [3:0] nib;
        nib = 4'($urandom);
        sample_valid = sv;
        sample = {c[11:0], nib};
        clear_fault = clr;
        reset = rst;
        @(posedge clk);
        model_step(sv, c, clr, rst);
        #1;
        compare_all();
    endtask

    // n samples of one code; rnd adds idle gaps, clear pulses and rare resets.
    task automatic feed(string name, int c, int n, bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2))
                    cycle(0, 0, $urandom_range(0, 5) == 0, $urandom_range(0, 399) == 0);
            end
            cycle(1, c, rnd && $urandom_range(0, 5) == 0, 1'b0);
        end
        $display("%s: code=%0d n=%0d avg=%0d state a=%0d b=%0d", name, c, n, m_avg, m_state[0], m_state[1]);
    endtask

    task automatic idle(int n, bit clr);
        repeat (n) cycle(0, 0, clr, 1'b0);
    endtask

    initial begin
        int levels[12] = '{0, 300, 500, 799, 800, 849, 949, 950, 951, 1200, 4095, 0};
        repeat (3) cycle(0, 0, 0, 1);

        // Fill then one more sample at 0x1F40 (code 500)
        feed("fill", 500, 8, 0);
        idle(2, 0);
        feed("first_avg", 500, 1, 0);
        idle(2, 0);

        // Debounce: 949 never trips, 3 qualifying then 949 restarts the count
        feed("hold_949", 949, 20, 0);
        feed("rise_950", 950, 10, 0);
        feed("dip_949", 942, 1, 0);
        feed("back_950", 950, 8, 0);
        feed("trip_950", 950, 3, 0);
        idle(2, 0);

        // Clear hysteresis
        feed("fault_850", 850, 8, 0);
        idle(1, 1);
        idle(2, 0);
        feed("fault_799", 799, 8, 0);
        idle(1, 1);
        idle(2, 0);

        // Window wrap with back-to-back alternating extremes
        for (int i = 0; i < 16; i++) cycle(1, (i % 2) ? 4095 : 0, 0, 0);
        $display("wrap: avg=%0d state a=%0d b=%0d", m_avg, m_state[0], m_state[1]);
        idle(2, 0);

        // Reset mid-FAULT, then mid-FILL
        feed("to_fault", 4095, 8, 0);
        idle(1, 0);
        cycle(0, 0, 0, 1);
        feed("part_fill", 500, 4, 0);
        cycle(1, 500, 0, 1);
        feed("refill", 500, 8, 0);
        idle(1, 0);
        feed("after_refill", 500, 1, 0);

        // Random bursts
        for (int b = 0; b < 150; b++) begin
            int c;
            c = (b % 12 == 11) ? int'($urandom_range(0, 4095)) : levels[$urandom_range(0, 10)];
            if ($urandom_range(0, 3) == 0) begin
                c = c + int'($urandom_range(0, 4)) - 2;
                if (c < 0) c = 0;
                if (c > 4095) c = 4095;
            end
            feed("burst", c, $urandom_range(1, 12), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/current_monitor.md
Name: current_monitor

Overview:
- Downstream consumer of the XADC current sensor stage.
- Takes raw 16-bit XADC conversion words and forms a moving-average motor current.
- Runs a debounced, hysteretic overcurrent trip and gates motor drive through a latched fault.
- Sits between the current sensor and the PWM/motor driver enable.

Parameters:
AVG_LOG2, 3, log2 of moving-average window length (window = 8 samples); legal range 1..5
TRIP_LEVEL, 950, 12-bit code at or above which an averaged sample counts toward a trip
CLEAR_LEVEL, 800, 12-bit code strictly below which a fault may be cleared; must be < TRIP_LEVEL
TRIP_COUNT, 4, consecutive averaged samples >= TRIP_LEVEL needed to trip; range 1..15

Ports:
clk  input  1  system clock, the only clock
reset  input  1  synchronous, active-high reset
sample  input  16  raw XADC word; 12-bit result in sample[15:4], low nibble ignored
sample_valid  input  1  one-cycle strobe marking sample as a new conversion
clear_fault  input  1  level request to leave FAULT
avg_current  output  12  moving-average current code
avg_valid  output  1  one-cycle pulse when avg_current updates
peak_current  output  12  largest averaged code since reset or last fault clear
fault  output  1  latched overcurrent fault
motor_enable  output  1  drive permission to the PWM stage
state_out  output  2  current FSM state, for debug/LEDs

Behaviour:
- Reset, sampled on clk: all outputs 0, state FILL, history buffer and running sum cleared, trip counter 0, fill counter 0.
- Sample accept, cycle t with sample_valid=1:
  - code = sample[15:4].
  - Circular buffer of 2^AVG_LOG2 x 12 bits; write pointer wraps modulo window.
  - sum <= sum + code - buf[wr_ptr]; buf[wr_ptr] <= code; wr_ptr++.
  - Sum width is 12+AVG_LOG2 bits and never overflows or underflows.
  - With sample_valid=0 nothing changes, including the pointer and sum.
- Averaging: at t+1, avg_current = sum >> AVG_LOG2 (truncating). avg_valid pulses for one cycle at t+1 only outside FILL.
- FSM, evaluated on the cycle avg_valid is high (t+1); resulting outputs appear at t+2:
  - FILL: motor_enable=0, fault=0. Counts accepted samples. Enters ARMED after 2^AVG_LOG2 samples; the first avg_valid comes with the next accepted sample.
  - ARMED: motor_enable=1.
    - avg >= TRIP_LEVEL increments the trip counter; avg < TRIP_LEVEL zeroes it.
    - When the counter reaches TRIP_COUNT, go to FAULT.
    - peak_current <= max(peak_current, avg).
  - FAULT: fault=1, motor_enable=0, trip counter held at 0.
    - Averaging continues and avg_valid keeps pulsing.
    - Leave only when clear_fault=1 and the most recent avg_current < CLEAR_LEVEL. Then go to ARMED, fault=0, peak_current=0, counter=0.
    - clear_fault while avg >= CLEAR_LEVEL is ignored. clear_fault is not latched.
  - state_out encoding: FILL=0, ARMED=1, FAULT=2; 3 is unused and recovers to FILL.
- motor_enable and fault are registered and mutually exclusive at all times.
- Simultaneous events:
  - clear_fault together with an avg_valid that re-trips: the clear is evaluated on the previous avg. The new avg starts a fresh count in ARMED, so no immediate re-fault unless TRIP_COUNT=1.
  - reset overrides everything, including mid-FILL and FAULT.
- A window with sample_valid on back-to-back cycles must be supported (one sample per clk).

Decomposition:
- Package current_monitor_pkg holds:
  - state enum: FILL, ARMED, FAULT
  - ADC_CODE_W=12
  - function to extract code from an XADC word
- One sub-module, moving_avg: buffer, pointer, running sum, avg/avg_valid pipeline.
- The FSM, trip counter and peak tracker stay in the top.

Test Plan:
- Reset then 8 samples of 0x1F40 -> state_out 0 until the 8th; state_out=1 and motor_enable=1 at t+2 after the 8th. Next sample gives avg_current=500 with avg_valid for one cycle.
- Debounce check: in ARMED, drive a steady code 950 (0x3B60) until avg=950. After 4 consecutive avg_valid at 950, fault=1 and motor_enable=0. A run of only 3 followed by avg 949 must not trip and resets the count.
- Boundary: avg exactly 949 for 20 samples -> no fault. Avg exactly 950 with TRIP_COUNT=1 -> fault on the first qualifying avg.
- Clear hysteresis: in FAULT with avg=850, pulse clear_fault -> fault stays 1. Drop to avg=799, pulse clear_fault -> fault=0, motor_enable=1, peak_current=0 next cycle.
- Window wrap: feed 16 alternating codes 0 and 4095 on consecutive cycles -> avg_current settles at 2047. Sum stays consistent across pointer wrap.
- Reset mid-FAULT and mid-FILL -> all outputs 0 the next cycle, state_out=0, and 8 fresh samples are required before motor_enable rises.
